// File: rtl/multiplier_operand_writer.sv
// Write-side producer for the multiplier operand FIFO: emits a burst of packed {a,b}
// words, stepping a and b after each one and writing only when the FIFO reports room.
module multiplier_operand_writer #(
   parameter int MIN_FREE   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_sig,
   input  logic [7:0]  a_init,
   input  logic [7:0]  b_init,
   input  logic [7:0]  a_step,
   input  logic [7:0]  b_step,
   input  logic [7:0]  count,
   input  logic [2:0]  left_sig,
   output logic        write_req,
   output logic [15:0] fifo_write_data,
   output logic        busy,
   output logic        done_sig
);

   // left_sig never exceeds the FIFO depth, so a larger threshold could never be met.
   localparam int          THRESH     = (MIN_FREE > FIFO_DEPTH) ? FIFO_DEPTH : MIN_FREE;
   localparam logic [2:0]  THRESH_LSB = 3'(THRESH);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WRITE,
      SETTLE,
      DONE
   } state_t;

   state_t     state;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] step_a;
   logic [7:0] step_b;
   logic [7:0] remaining;

   function automatic logic [7:0] wrap_add(input logic [7:0] x, input logic [7:0] s);
      logic [8:0] sum;
      sum = {1'b0, x} + {1'b0, s};
      return sum[7:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         a               <= 8'h00;
         b               <= 8'h00;
         step_a          <= 8'h00;
         step_b          <= 8'h00;
         remaining       <= 8'h00;
         write_req       <= 1'b0;
         fifo_write_data <= 16'h0000;
         busy            <= 1'b0;
         done_sig        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               write_req <= 1'b0;
               done_sig  <= 1'b0;
               if (start_sig) begin
                  a         <= a_init;
                  b         <= b_init;
                  step_a    <= a_step;
                  step_b    <= b_step;
                  remaining <= count;
                  busy      <= 1'b1;
                  state     <= (count != 8'h00) ? CHECK : DONE;
               end
            end
            CHECK: begin
               if (left_sig >= THRESH_LSB) begin
                  write_req       <= 1'b1;
                  fifo_write_data <= {a, b};
                  state           <= WRITE;
               end
            end
            WRITE: begin
               write_req <= 1'b0;
               a         <= wrap_add(a, step_a);
               b         <= wrap_add(b, step_b);
               remaining <= remaining - 8'h01;
               state     <= SETTLE;
            end
            // One idle cycle so left_sig reflects the write just issued.
            SETTLE: begin
               state <= (remaining == 8'h00) ? DONE : CHECK;
            end
            DONE: begin
               done_sig <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               write_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/multiplier_operand_writer.md
Name: multiplier_operand_writer

Overview:
- Producer for the operand FIFO that feeds the pipelined LUT multiplier. Its job is the write side of the FIFO handshake.
- On a start request it generates a burst of N packed operand words {a[7:0], b[7:0]}. After each word, a and b advance by programmable steps.
- Each word is pushed into the FIFO only when the FIFO's free-slot count (left_sig) shows room.
- Sits beside the multiplier interface, which drains the same FIFO from the other end.

Parameters:
- MIN_FREE, 1, minimum left_sig value (free slots) needed before a write is issued.
- FIFO_DEPTH, 4, depth of the target FIFO. Informational; left_sig never exceeds it.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_sig  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- a_init  in  8  first a operand; latched on accepted start.
- b_init  in  8  first b operand; latched on accepted start.
- a_step  in  8  added to a after each word, modulo 256.
- b_step  in  8  added to b after each word, modulo 256.
- count  in  8  number of words in the burst; 0 means no words.
- left_sig  in  3  free slots remaining in the FIFO, range 0..FIFO_DEPTH.
- write_req  out  1  FIFO write strobe, one cycle wide.
- fifo_write_data  out  16  packed word: {a, b}, with a in [15:8] and b in [7:0].
- busy  out  1  high from accepted start until the cycle done_sig is asserted.
- done_sig  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Interface:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - All outputs are registered.
- Reset values: write_req=0, fifo_write_data=16'h0000, busy=0, done_sig=0. Internal a, b and remaining are 0; state is IDLE.
- Reset mid-burst: outputs take their reset values immediately, without waiting for a clock. Any write_req in flight is dropped and no partial burst resumes.
- States: IDLE, CHECK, WRITE, SETTLE, DONE.
- IDLE:
  - If start_sig=1, latch a_init, b_init, a_step, b_step and count into remaining, and set busy=1.
  - Next state is CHECK if count!=0, else DONE.
  - start_sig in any other state is ignored; it is not queued.
- CHECK:
  - If left_sig>=MIN_FREE: write_req<=1, fifo_write_data<={a,b}, go to WRITE.
  - Otherwise stay in CHECK. write_req stays 0 and there is no timeout.
- WRITE:
  - write_req<=0, a<=a+a_step, b<=b+b_step (each 8-bit, wrap-around), remaining<=remaining-1.
  - Go to SETTLE.
- SETTLE:
  - Go to DONE if remaining==0, else CHECK.
  - This cycle gives left_sig time to reflect the write just made, so the block cannot over-fill the FIFO on a stale count.
- DONE:
  - done_sig<=1 for exactly one cycle, busy<=0, go to IDLE.
  - done_sig is cleared in the following cycle.
- Timing:
  - write_req is high for exactly one cycle per word.
  - With room always available, consecutive write_req pulses are 3 cycles apart: CHECK, WRITE, SETTLE.
  - First write_req is high 2 cycles after the start_sig edge.
  - done_sig is high 3 cycles after the last write_req.
- fifo_write_data holds its last value between writes; it changes only in the cycle write_req rises.
- Simultaneous events: left_sig changing in the same cycle as a CHECK decision uses the pre-edge sampled value.
- A new burst can be accepted in the cycle after done_sig.

Test Plan:
- Basic burst: left_sig=4 held, start with a=0x03, b=0x05, steps 1/1, count=3.
  → write_req pulses carry 0x0305, 0x0406, 0x0507, spaced 3 cycles apart.
  → done_sig is one cycle wide, 3 cycles after the last pulse; busy drops with it.
- Backpressure: left_sig=0 for 20 cycles after start.
  → no write_req, busy=1 throughout.
  → Raise left_sig to 1: write_req follows within 2 cycles with data {a_init,b_init}.
- Wrap-around: a=0xFF, a_step=0x01, b=0x00, b_step=0xFF, count=2.
  → data sequence 0xFF00, then 0x00FF.
- Zero count and ignored start: count=0.
  → done_sig pulses, no write_req ever, busy low afterwards.
  → A second start_sig during a count=5 burst: exactly 5 writes still occur.
- Reset mid-burst: assert rst_n=0 between the 2nd and 3rd write.
  → write_req, busy and done_sig go 0 asynchronously.
  → After release, a new start with a=0x10, b=0x20 writes 0x1020 first.
- System check with the FIFO (depth 4) and multiplier interface, count=8, a 1..8, b=2.
  → no FIFO overflow.
  → product stream 2, 4, ..., 16 in order.
